udp_width_conv: RTL and testbench

Parametrised successor to the fixed 32-to-16-bit UDP payload converter. Takes wide payload words from the UDP receive path and splits each into RATIO = IN_W/OUT_W narrow words, MSB-first or LSB-first. A small input FIFO absorbs backpressure from the SDRAM write port. The block adds partial-last-word handling, frame-end marking and overflow accounting. It sits between udp rec_en/rec_data and the sdram_top write FIFO, in the eth_rx_clk domain.

---
 rtl/udp_conv_pkg.sv | 23 ++
 rtl/sync_fifo_fwft.sv | 45 ++++
 rtl/udp_width_conv.sv | 157 +++++++++++++++
 tb/tb_udp_width_conv.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_conv_pkg.sv
// udp_conv_pkg: shared definitions for the UDP payload width converter.
// Holds the default width ratio, the slice-index width, the converter FSM
// encoding and a constant clog2 helper used to size pointers and counters.
package udp_conv_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int IN_W_DEF  = 32;
  localparam int OUT_W_DEF = 16;
  localparam int RATIO     = IN_W_DEF / OUT_W_DEF;
  localparam int SLC_W     = clog2(RATIO);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO with registered pointers.
// Ports: clk/rst (async active-high), push/din write side, pop/dout read side,
//        full/empty status. Caller must never push when full without a pop.
module sync_fifo_fwft
  import udp_conv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/udp_width_conv.sv
// udp_width_conv: splits IN_W payload words into IN_W/OUT_W slices of OUT_W bits.
// Ports: in_valid/in_data/in_last/in_nwords from the UDP receiver (cannot stall),
//        in_ready (= !fifo_full), out_valid/out_ready/out_data/out_last to the
//        SDRAM write FIFO, ovf/drop_cnt overflow statistics cleared by clr_stat.
module udp_width_conv
  import udp_conv_pkg::*;
#(
  parameter int IN_W      = 32,
  parameter int OUT_W     = 16,
  parameter int DEPTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 16,
  localparam int NSLC     = IN_W / OUT_W,
  localparam int IDX_W    = clog2(NSLC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  input  logic [IDX_W:0]   in_nwords,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             ovf,
  output logic [CNT_W-1:0] drop_cnt,
  input  logic             clr_stat
);

  localparam int            EW      = IN_W + 1 + IDX_W + 1;
  localparam logic [IDX_W:0] FULL_NW = (IDX_W+1)'(NSLC);

  // FIFO entry layout: {data, last, effective slice count}
  logic [EW-1:0]   fifo_din;
  logic [EW-1:0]   fifo_dout;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            drop;
  logic [IDX_W:0]  eff_nw;

  logic [IN_W-1:0] head_data;
  logic            head_last;
  logic [IDX_W:0]  head_nw;

  state_t           state;
  state_t           next_state;
  logic [IN_W-1:0]  shreg;
  logic [IDX_W-1:0] slice_idx;
  logic [IDX_W:0]   nslc;
  logic             cur_last;
  logic             shift;
  logic             at_end;

  // A count of 0 (or any non-last word) means a whole word of slices.
  assign eff_nw   = (in_last && (in_nwords != '0)) ? in_nwords : FULL_NW;
  assign fifo_din = {in_data, in_last, eff_nw};

  assign head_data = fifo_dout[EW-1 -: IN_W];
  assign head_last = fifo_dout[IDX_W+1];
  assign head_nw   = fifo_dout[IDX_W:0];

  // A pop in the same cycle frees a slot, so a push onto a full FIFO is
  // still accepted then; only a push with no room and no pop is dropped.
  assign push     = in_valid && (!fifo_full || pop);
  assign drop     = in_valid && fifo_full && !pop;
  assign in_ready = !fifo_full;

  sync_fifo_fwft #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign at_end = ({1'b0, slice_idx} == (nslc - (IDX_W+1)'(1)));

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    shift      = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (!at_end) begin
            shift = 1'b1;
          end else if (!fifo_empty) begin
            // Load the next word immediately so the stream has no bubble.
            pop = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs come straight from registers, so they hold while stalled and
  // out_valid drops as soon as reset is asserted.
  assign out_valid = (state == EMIT);
  assign out_last  = (state == EMIT) && at_end && cur_last;
  assign out_data  = (MSB_FIRST != 0) ? shreg[IN_W-1 -: OUT_W] : shreg[OUT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      slice_idx <= '0;
      nslc      <= FULL_NW;
      cur_last  <= 1'b0;
    end else begin
      state <= next_state;
      if (pop) begin
        shreg     <= head_data;
        slice_idx <= '0;
        nslc      <= head_nw;
        cur_last  <= head_last;
      end else if (shift) begin
        // Move the next slice toward the emit end of the register.
        shreg     <= (MSB_FIRST != 0) ? (shreg << OUT_W) : (shreg >> OUT_W);
        slice_idx <= slice_idx + (IDX_W)'(1);
      end
    end
  end

  // Clear takes priority but a drop in the same cycle is still recorded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_stat) begin
      ovf      <= drop;
      drop_cnt <= drop ? CNT_W'(1) : '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (drop_cnt != {CNT_W{1'b1}}) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_udp_width_conv.sv
// tb_udp_width_conv: self-checking bench for udp_width_conv.
// Instance a: default 32->16 MSB-first, DEPTH 8. Instance b: 64->16 LSB-first,
// DEPTH 4, CNT_W 4. Inputs change 1ns after posedge; outputs sampled at negedge.
`timescale 1ns/1ps
module tb_udp_width_conv;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        a_in_valid, a_in_last, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_ovf, a_clr;
  logic [31:0] a_in_data;
  logic [1:0]  a_in_nwords;
  logic [15:0] a_out_data, a_drop_cnt;

  logic        b_in_valid, b_in_last, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_ovf, b_clr;
  logic [63:0] b_in_data;
  logic [2:0]  b_in_nwords;
  logic [15:0] b_out_data;
  logic [3:0]  b_drop_cnt;

  udp_width_conv #(.IN_W(32), .OUT_W(16), .DEPTH(8), .MSB_FIRST(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_data(a_in_data), .in_last(a_in_last),
    .in_nwords(a_in_nwords), .in_ready(a_in_ready), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_last(a_out_last),
    .ovf(a_ovf), .drop_cnt(a_drop_cnt), .clr_stat(a_clr));

  udp_width_conv #(.IN_W(64), .OUT_W(16), .DEPTH(4), .MSB_FIRST(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data), .in_last(b_in_last),
    .in_nwords(b_in_nwords), .in_ready(b_in_ready), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last),
    .ovf(b_ovf), .drop_cnt(b_drop_cnt), .clr_stat(b_clr));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference stream for instance a: every slice the sink should accept, in order.
  typedef struct packed { logic [15:0] d; logic l; } slc_t;
  slc_t exp_q[$];
  bit   mon_en = 0;
  bit   prev_stall = 0;
  logic [15:0] prev_d;
  logic        prev_l;

  function automatic void model_word(input logic [31:0] d, input logic last, input logic [1:0] nw);
    int n;
    n = (last && nw != 2'd0) ? int'(nw) : 2;
    for (int k = 0; k < n; k++) begin
      slc_t s;
      s.d = 16'(d >> (32 - 16 * (k + 1)));
      s.l = last && (k == n - 1);
      exp_q.push_back(s);
    end
  endfunction

  task automatic mon();
    slc_t s;
    if (prev_stall) begin
      chk("hold_valid", a_out_valid, 1'b1);
      chk("hold_data", a_out_data, prev_d);
      chk("hold_last", a_out_last, prev_l);
    end
    if (a_out_valid && a_out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL extra_slice: got %0h, expected no slice", a_out_data);
      end else begin
        s = exp_q.pop_front();
        chk("slice_data", a_out_data, s.d);
        chk("slice_last", a_out_last, s.l);
      end
    end
    prev_stall = a_out_valid && !a_out_ready;
    prev_d     = a_out_data;
    prev_l     = a_out_last;
  endtask

  task automatic sample();
    @(negedge clk);
    if (mon_en) mon();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    sample();
    adv();
  endtask

  task automatic mon_on();
    exp_q.delete();
    prev_stall = 0;
    mon_en = 1;
  endtask

  typedef struct {
    logic [31:0] d;
    logic        last;
    logic [1:0]  nw;
    int          n;
    logic [15:0] s0;
    logic [15:0] s1;
    logic        lst;
  } vec_t;
  vec_t tbl[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int got;
    logic [15:0] exp_d;
    logic [15:0] bexp[3];

    tbl[0] = '{32'hAABBCCDD, 1'b0, 2'd0, 2, 16'hAABB, 16'hCCDD, 1'b0};
    tbl[1] = '{32'h11223344, 1'b1, 2'd0, 2, 16'h1122, 16'h3344, 1'b1};
    tbl[2] = '{32'hDEADBEEF, 1'b1, 2'd1, 1, 16'hDEAD, 16'h0000, 1'b1};
    tbl[3] = '{32'h0F0FF0F0, 1'b1, 2'd2, 2, 16'h0F0F, 16'hF0F0, 1'b1};
    tbl[4] = '{32'h12345678, 1'b0, 2'd1, 2, 16'h1234, 16'h5678, 1'b0};
    tbl[5] = '{32'h5A5AA5A5, 1'b1, 2'd1, 1, 16'h5A5A, 16'h0000, 1'b1};

    rst = 1'b1;
    a_in_valid = 0; a_in_data = '0; a_in_last = 0; a_in_nwords = '0; a_out_ready = 1; a_clr = 0;
    b_in_valid = 0; b_in_data = '0; b_in_last = 0; b_in_nwords = '0; b_out_ready = 1; b_clr = 0;
    adv(); adv();
    rst = 1'b0;

    // Reset state
    sample();
    chk("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_out_data", a_out_data, 16'h0);
    chk("rst_out_last", a_out_last, 1'b0);
    chk("rst_ovf", a_ovf, 1'b0);
    chk("rst_drop_cnt", a_drop_cnt, 16'h0);
    chk("rst_in_ready", a_in_ready, 1'b1);
    chk("rst_b_out_valid", b_out_valid, 1'b0);
    adv();

    // Two-word packet: first slice two cycles after the push, then back to back
    a_in_valid = 1; a_in_data = 32'hAABBCCDD; a_in_last = 0; a_in_nwords = 0;
    sample(); chk("lat_t0_valid", a_out_valid, 1'b0); adv();
    a_in_data = 32'h11223344; a_in_last = 1;
    sample(); chk("lat_t1_valid", a_out_valid, 1'b0); adv();
    a_in_valid = 0; a_in_last = 0;
    sample(); chk("lat_s0_valid", a_out_valid, 1'b1); chk("lat_s0_data", a_out_data, 16'hAABB);
    chk("lat_s0_last", a_out_last, 1'b0); adv();
    sample(); chk("lat_s1_data", a_out_data, 16'hCCDD); chk("lat_s1_last", a_out_last, 1'b0); adv();
    sample(); chk("lat_s2_data", a_out_data, 16'h1122); chk("lat_s2_last", a_out_last, 1'b0); adv();
    sample(); chk("lat_s3_data", a_out_data, 16'h3344); chk("lat_s3_last", a_out_last, 1'b1); adv();
    sample(); chk("lat_end_valid", a_out_valid, 1'b0); adv();

    // Table of single words with various last/nwords combinations
    for (int i = 0; i < 6; i++) begin
      a_in_valid = 1; a_in_data = tbl[i].d; a_in_last = tbl[i].last; a_in_nwords = tbl[i].nw;
      got = 0;
      for (int c = 0; c < 8; c++) begin
        sample();
        if (a_out_valid) begin
          exp_d = (got == 0) ? tbl[i].s0 : tbl[i].s1;
          chk($sformatf("vec%0d_data%0d", i, got), a_out_data, exp_d);
          chk($sformatf("vec%0d_last%0d", i, got), a_out_last, tbl[i].lst && (got == tbl[i].n - 1));
          got++;
        end
        adv();
        a_in_valid = 0;
      end
      chk($sformatf("vec%0d_count", i), got, tbl[i].n);
    end
    a_in_last = 0; a_in_nwords = 0;

    // Backpressure: 12 words while stalled. The first word is loaded into the
    // shift register, eight fill the FIFO, the remaining three are dropped.
    mon_on();
    a_out_ready = 0;
    for (int i = 0; i < 12; i++) begin
      a_in_valid = 1; a_in_data = {16'h1000 + 16'(i), 16'h2000 + 16'(i)};
      if (i <= 8) model_word(a_in_data, 1'b0, 2'd0);
      cyc();
    end
    a_in_valid = 0;
    for (int i = 0; i < 8; i++) cyc();
    sample();
    chk("bp_ovf", a_ovf, 1'b1);
    chk("bp_drop_cnt", a_drop_cnt, 16'd3);
    chk("bp_in_ready", a_in_ready, 1'b0);
    chk("bp_held_data", a_out_data, 16'h1000);
    adv();
    a_out_ready = 1;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) cyc();
    sample();
    chk("bp_drained", exp_q.size(), 0);
    chk("bp_idle", a_out_valid, 1'b0);
    adv();

    // Statistics clear
    a_clr = 1; cyc(); a_clr = 0;
    sample(); chk("clr_ovf", a_ovf, 1'b0); chk("clr_drop_cnt", a_drop_cnt, 16'd0); adv();

    // Full FIFO with a pop coinciding with a push, then real drops incl. clear+drop
    a_out_ready = 0;
    for (int i = 0; i < 9; i++) begin
      a_in_valid = 1; a_in_data = {16'h3000 + 16'(i), 16'h4000 + 16'(i)};
      model_word(a_in_data, 1'b0, 2'd0);
      cyc();
    end
    a_in_valid = 0; a_out_ready = 1;
    sample(); chk("pf_full_a", a_in_ready, 1'b0); adv();
    a_in_valid = 1; a_in_data = 32'h30094009;
    model_word(a_in_data, 1'b0, 2'd0);
    sample(); chk("pf_full_b", a_in_ready, 1'b0); adv();
    a_out_ready = 0; a_in_data = 32'hEEEEEEEE;
    sample(); chk("pf_no_drop", a_drop_cnt, 16'd0); chk("pf_no_ovf", a_ovf, 1'b0);
    chk("pf_still_full", a_in_ready, 1'b0); adv();
    a_clr = 1;
    sample(); chk("drop_one", a_drop_cnt, 16'd1); chk("drop_ovf", a_ovf, 1'b1); adv();
    a_clr = 0; a_in_valid = 0;
    sample(); chk("clr_drop_cnt", a_drop_cnt, 16'd1); chk("clr_drop_ovf", a_ovf, 1'b1); adv();
    a_out_ready = 1;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) cyc();
    sample(); chk("pf_drained", exp_q.size(), 0); adv();
    mon_en = 0;

    // Instance b: LSB-first, partial last word of three slices
    b_in_valid = 1; b_in_data = 64'h0001_0002_0003_0004; b_in_last = 1; b_in_nwords = 3'd3;
    bexp[0] = 16'h0004; bexp[1] = 16'h0003; bexp[2] = 16'h0002;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      sample();
      if (b_out_valid) begin
        if (got < 3) begin
          chk($sformatf("b_data%0d", got), b_out_data, bexp[got]);
          chk($sformatf("b_last%0d", got), b_out_last, got == 2);
        end
        got++;
      end
      adv();
      b_in_valid = 0;
    end
    chk("b_count", got, 3);

    // Instance b: 20 drops saturate a 4-bit counter
    b_out_ready = 0; b_in_last = 0;
    for (int i = 0; i < 25; i++) begin
      b_in_valid = 1; b_in_data = 64'(i);
      cyc();
    end
    b_in_valid = 0;
    sample();
    chk("b_sat_cnt", b_drop_cnt, 4'hF);
    chk("b_sat_ovf", b_ovf, 1'b1);
    chk("b_sat_in_ready", b_in_ready, 1'b0);
    adv();
    b_out_ready = 1;

    // Reset in the middle of a word
    a_out_ready = 1;
    a_in_valid = 1; a_in_data = 32'hCAFEF00D; a_in_last = 0; a_in_nwords = 0;
    cyc();
    a_in_data = 32'h0BADBEEF; a_in_last = 1;
    cyc();
    a_in_valid = 0; a_in_last = 0;
    sample();
    chk("mid_pre_valid", a_out_valid, 1'b1);
    chk("mid_pre_data", a_out_data, 16'hCAFE);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", a_out_valid, 1'b0);
    chk("mid_rst_in_ready", a_in_ready, 1'b1);
    chk("mid_rst_ovf", a_ovf, 1'b0);
    chk("mid_rst_drop", a_drop_cnt, 16'd0);
    chk("mid_rst_b_drop", b_drop_cnt, 4'h0);
    adv(); adv();
    rst = 1'b0;
    sample(); chk("post_rst_idle0", a_out_valid, 1'b0); adv();
    sample(); chk("post_rst_idle1", a_out_valid, 1'b0); adv();
    a_in_valid = 1; a_in_data = 32'h13579BDF; a_in_last = 1; a_in_nwords = 0;
    sample(); chk("post_t0", a_out_valid, 1'b0); adv();
    a_in_valid = 0; a_in_last = 0;
    sample(); chk("post_t1", a_out_valid, 1'b0); adv();
    sample(); chk("post_s0_valid", a_out_valid, 1'b1); chk("post_s0_data", a_out_data, 16'h1357);
    chk("post_s0_last", a_out_last, 1'b0); adv();
    sample(); chk("post_s1_data", a_out_data, 16'h9BDF); chk("post_s1_last", a_out_last, 1'b1); adv();
    sample(); chk("post_idle", a_out_valid, 1'b0); adv();

    // Random traffic against the reference stream. Pushes are only offered
    // while fewer than DEPTH slices are outstanding, so no word can be dropped.
    mon_on();
    for (int c = 0; c < 1500; c++) begin
      a_out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0 && exp_q.size() < 8) begin
        a_in_valid  = 1;
        a_in_data   = $urandom;
        a_in_last   = $urandom_range(0, 1);
        a_in_nwords = 2'($urandom_range(0, 2));
        model_word(a_in_data, a_in_last, a_in_nwords);
      end else begin
        a_in_valid = 0;
      end
      cyc();
    end
    a_in_valid = 0; a_out_ready = 1;
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) cyc();
    sample();
    chk("rnd_drained", exp_q.size(), 0);
    chk("rnd_no_drop", a_drop_cnt, 16'd0);
    chk("rnd_idle", a_out_valid, 1'b0);
    adv();
    mon_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
